// File: rtl/filter_loader.sv
// Packs a serial byte stream into 4-lane groups and writes each group into the
// filter buffer with a single load pulse, then pulses done once the filter is resident.
module filter_loader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   filter_len,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data [0:3],
    output logic              load,
    output logic [ADDR_W-1:0] write_address,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          lane_q, lane_d;
    logic [DATA_W-1:0]   lane_reg_q [0:3];
    logic [DATA_W-1:0]   lane_reg_d [0:3];
    logic [DATA_W-1:0]   out_data_q [0:3];
    logic [DATA_W-1:0]   out_data_d [0:3];
    logic [ADDR_W-1:0]   write_address_q, write_address_d;
    logic                in_ready_q, in_ready_d;
    logic                load_q, load_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready are both high;
    // in_ready is only ever high in COLLECT, and the source must hold in_data until it transfers.
    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        addr_d          = addr_q;
        lane_d          = lane_q;
        lane_reg_d      = lane_reg_q;
        out_data_d      = out_data_q;
        write_address_d = write_address_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = (filter_len > LEN_MAX) ? LEN_MAX : filter_len;
                    addr_d      = base_addr;
                    lane_d      = 2'd0;
                    lane_reg_d  = '{default: '0};
                    state_d     = (remaining_d != '0) ? S_COLLECT : S_DONE;
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    lane_reg_d[lane_q] = in_data;
                    lane_d             = lane_q + 2'd1;
                    remaining_d        = remaining_q - 1'b1;
                    // The group closes on lane 3 or on the final byte of the filter.
                    if (lane_q == 2'd3 || remaining_q == 1) begin
                        state_d         = S_WRITE;
                        out_data_d      = lane_reg_d;
                        write_address_d = addr_q;
                    end
                end
            end
            S_WRITE: begin
                addr_d     = addr_q + ADDR_W'(4);
                lane_d     = 2'd0;
                lane_reg_d = '{default: '0};
                state_d    = (remaining_q == '0) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_COLLECT);
        load_d     = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            remaining_q     <= '0;
            addr_q          <= '0;
            lane_q          <= 2'd0;
            lane_reg_q      <= '{default: '0};
            out_data_q      <= '{default: '0};
            write_address_q <= '0;
            in_ready_q      <= 1'b0;
            load_q          <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            addr_q          <= addr_d;
            lane_q          <= lane_d;
            lane_reg_q      <= lane_reg_d;
            out_data_q      <= out_data_d;
            write_address_q <= write_address_d;
            in_ready_q      <= in_ready_d;
            load_q          <= load_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_data      = out_data_q;
    assign load          = load_q;
    assign write_address = write_address_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign dbg_state     = state_q;

endmodule
